zeta_addr_seq: RTL and testbench

//  Sequenced, parametrised twiddle-address generator for the NUM_BU-lane butterfly array.
//  One start pulse runs every NTT (or INTT) layer of an N-point transform.

---
 rtl/zeta_addr_seq.sv | 81 ++++++++
 tb/tb_zeta_addr_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/zeta_addr_seq.sv
// zeta_addr_seq: per-lane zeta ROM address stream covering every layer of an N-point NTT/INTT
module zeta_addr_seq #(
  parameter int N          = 256,
  parameter int NUM_BU     = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         is_ntt,
  input  logic                         ready_in,
  output logic                         valid_out,
  output logic [NUM_BU*ADDR_WIDTH-1:0] addr_zeta,
  output logic [$clog2(N)-1:0]         len_out,
  output logic                         layer_last,
  output logic                         frame_last,
  output logic                         busy,
  output logic                         done
);
  localparam int LOGN = $clog2(N);
  localparam int CPL  = N / (2 * NUM_BU);
  localparam int NL   = LOGN - 1;
  localparam int CW   = CPL > 1 ? $clog2(CPL) : 1;
  localparam int LW   = NL > 1 ? $clog2(NL) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         st, st_nx;
  logic [CW-1:0]  c, c_nx;
  logic [LW-1:0]  l, l_nx;
  logic           ntt, ntt_nx;
  logic           c_end, l_end;
  logic [LOGN-1:0] b, a;
  assign c_end = c == CW'(CPL - 1);
  assign l_end = l == LW'(NL - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= IDLE;
      c   <= '0;
      l   <= '0;
      ntt <= 1'b0;
    end else begin
      st  <= st_nx;
      c   <= c_nx;
      l   <= l_nx;
      ntt <= ntt_nx;
    end
  end
  always_comb begin
    st_nx  = st;
    c_nx   = c;
    l_nx   = l;
    ntt_nx = ntt;
    if (st == IDLE && start) begin
      st_nx  = RUN;
      c_nx   = '0;
      l_nx   = '0;
      ntt_nx = is_ntt;
    end else if (st == RUN && ready_in) begin
      c_nx  = c_end ? '0 : c + 1'b1;
      l_nx  = c_end ? l + 1'b1 : l;
      st_nx = c_end && l_end ? DONE : RUN;
    end else if (st == DONE) begin
      st_nx = IDLE;
    end
  end
  always_comb begin
    busy       = st == RUN;
    valid_out  = busy;
    done       = st == DONE;
    layer_last = busy && c_end;
    frame_last = busy && c_end && l_end;
    len_out    = !busy ? '0 : ntt ? LOGN'(N / 2) >> l : LOGN'(2) << l;
    addr_zeta  = '0;
    b          = '0;
    a          = '0;
    for (int i = 0; i < NUM_BU; i++) begin
      b = LOGN'(i * CPL) + LOGN'(c);
      a = (LOGN'(1) << l) + (b >> (LOGN'(NL) - LOGN'(l)));
      if (busy) addr_zeta[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(a);
    end
  end
endmodule

// File: tb/tb_zeta_addr_seq.sv
// tb_zeta_addr_seq: scoreboard bench for zeta_addr_seq against an arithmetic reference model
module tb_zeta_addr_seq;
  localparam int N  = 256;
  localparam int AW = 7;
  localparam int NL = 7;
  typedef struct packed {
    logic [8*AW-1:0] addr;
    logic [7:0]      len;
    logic            ll;
    logic            fl;
  } beat_t;
  logic clk, rst_n;
  logic start0, ntt0, r0, v0, ll0, fl0, bz0, d0;
  logic [8*AW-1:0] a0;
  logic [7:0] len0;
  logic start1, ntt1, r1, v1, ll1, fl1, bz1, d1;
  logic [4*AW-1:0] a1;
  logic [7:0] len1;
  beat_t q0[$], q1[$];
  int n_chk, n_fail, acc0, acc1, dn0, dn1;
  logic stalled0;
  logic [66:0] held0;
  zeta_addr_seq #(.N(N), .NUM_BU(8), .ADDR_WIDTH(AW)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .is_ntt(ntt0), .ready_in(r0),
    .valid_out(v0), .addr_zeta(a0), .len_out(len0), .layer_last(ll0),
    .frame_last(fl0), .busy(bz0), .done(d0));
  zeta_addr_seq #(.N(N), .NUM_BU(4), .ADDR_WIDTH(AW)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .is_ntt(ntt1), .ready_in(r1),
    .valid_out(v1), .addr_zeta(a1), .len_out(len1), .layer_last(ll1),
    .frame_last(fl1), .busy(bz1), .done(d1));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int nbu, input bit ntt);
    int cpl, l, c, span, le;
    beat_t m;
    cpl = N / (2 * nbu);
    for (int k = 0; k < NL * cpl; k++) begin
      l = k / cpl;
      c = k % cpl;
      span = ntt ? (N / 2) >> l : 2 << l;
      le = ntt ? span : N / span;
      m.addr = '0;
      for (int i = 0; i < nbu; i++) m.addr[i*AW +: AW] = AW'((N / 2) / le + (i * cpl + c) / le);
      m.len = 8'(span);
      m.ll = c == cpl - 1;
      m.fl = m.ll && l == NL - 1;
      if (nbu == 8) q0.push_back(m);
      else q1.push_back(m);
    end
  endtask
  always @(negedge clk) begin
    beat_t e;
    if (v0 && r0) begin
      acc0++;
      if (q0.size() == 0) check("extra_beat0", 1, 0);
      else begin
        e = q0.pop_front();
        check("addr0", a0, e.addr);
        check("len0", len0, e.len);
        check("layer_last0", ll0, e.ll);
        check("frame_last0", fl0, e.fl);
      end
    end
    if (stalled0) check("hold0", {a0, len0, ll0, fl0, v0}, held0);
    stalled0 = v0 && !r0;
    held0 = {a0, len0, ll0, fl0, v0};
    if (d0) begin
      dn0++;
      check("done_idle0", {v0, bz0}, 0);
    end
  end
  always @(negedge clk) begin
    beat_t e;
    if (v1 && r1) begin
      acc1++;
      if (q1.size() == 0) check("extra_beat1", 1, 0);
      else begin
        e = q1.pop_front();
        check("addr1", a1, e.addr);
        check("len1", len1, e.len);
        check("layer_last1", ll1, e.ll);
        check("frame_last1", fl1, e.fl);
      end
    end
    if (d1) dn1++;
  end
  // modes: 0 ready=1, 1 random ready, 2 stall at beat 5, 3 stray starts, 4 reset at beat 40, 5 start in DONE
  task automatic run0(input bit ntt, input int mode);
    int base, d, cyc, stall, nb, bt;
    bit ab;
    nb = 112;
    push(8, ntt);
    base = acc0;
    d = dn0;
    cyc = 1;
    stall = 0;
    ab = 0;
    start0 = 1;
    ntt0 = ntt;
    r0 = 1;
    tick();
    start0 = 0;
    ntt0 = !ntt;
    while (dn0 == d && cyc < 1000 && !ab) begin
      bt = acc0 - base;
      r0 = mode == 1 ? ($urandom_range(0, 3) != 0) : !(mode == 2 && bt == 5 && stall < 3);
      if (mode == 2 && bt == 5 && stall < 3) stall++;
      start0 = (mode == 3 && (bt == 3 || bt == 60)) || (mode == 5 && bt == nb);
      if (mode == 4 && bt == 40) begin
        rst_n = 0;
        tick();
        check("rst_outputs0", {v0, a0, len0, ll0, fl0, bz0, d0}, 0);
        rst_n = 1;
        repeat (3) tick();
        check("rst_no_done0", dn0, d);
        q0.delete();
        ab = 1;
      end else begin
        tick();
        cyc++;
      end
    end
    start0 = 0;
    r0 = 1;
    if (!ab) begin
      check("timeout0", cyc < 1000, 1);
      check("nbeats0", acc0 - base, nb);
      check("qempty0", q0.size(), 0);
      if (mode != 1) check("latency0", cyc, nb + 2 + (mode == 2 ? 3 : 0));
      check("back_idle0", {bz0, d0, v0}, 0);
    end
  endtask
  task automatic run1(input bit ntt);
    int base, d, cyc;
    push(4, ntt);
    base = acc1;
    d = dn1;
    cyc = 0;
    start1 = 1;
    ntt1 = ntt;
    r1 = 1;
    tick();
    start1 = 0;
    while (dn1 == d && cyc < 2000) begin
      r1 = $urandom_range(0, 3) != 0;
      tick();
      cyc++;
    end
    r1 = 1;
    check("timeout1", cyc < 2000, 1);
    check("nbeats1", acc1 - base, 224);
    check("qempty1", q1.size(), 0);
  endtask
  initial begin
    n_chk = 0; n_fail = 0; acc0 = 0; acc1 = 0; dn0 = 0; dn1 = 0;
    stalled0 = 0; held0 = '0;
    rst_n = 0; start0 = 0; ntt0 = 0; r0 = 1; start1 = 0; ntt1 = 0; r1 = 1;
    repeat (2) tick();
    check("reset0", {v0, a0, len0, ll0, fl0, bz0, d0}, 0);
    check("reset1", {v1, a1, len1, ll1, fl1, bz1, d1}, 0);
    rst_n = 1;
    tick();
    run0(1, 0);
    run0(0, 0);
    run0(1, 2);
    run0(1, 1);
    run0(0, 1);
    run0(1, 3);
    run0(1, 5);
    run0(0, 0);
    run0(1, 4);
    run0(1, 0);
    run1(1);
    run1(0);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
